// File: rtl/arbitro_botones.sv
// Press/long-press event scheduler between the button debouncers and the main FSM.
// Build option: define LONG_PRESS_EN to add per-button long-press counters and events.

module arbitro_canal
`ifdef LONG_PRESS_EN
#(
  parameter int LONG_CNT = 8
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic boton,
  input  logic clr_s,
`ifdef LONG_PRESS_EN
  input  logic clr_l,
`endif
  output logic pend_s,
  output logic pend_l,
  output logic drop_hit
);
  logic prev;
  logic press;

  assign press    = boton & ~prev;
  // A press lost only if the pending one is not leaving this very cycle
  assign drop_hit = press & pend_s & ~clr_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= boton;
      pend_s <= 1'b0;
    end else begin
      prev   <= boton;
      pend_s <= (pend_s & ~clr_s) | press;
    end
  end

`ifdef LONG_PRESS_EN
  localparam int CW = $clog2(LONG_CNT);
  localparam logic [CW-1:0] CMAX = CW'(LONG_CNT - 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      pend_l <= 1'b0;
    end else begin
      if (!boton)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + CW'(1);
      // Fires only on the step into saturation, so once per hold
      pend_l <= (pend_l & ~clr_l) | (boton && cnt == CW'(LONG_CNT - 2));
    end
  end
`else
  assign pend_l = 1'b0;
`endif
endmodule

module arbitro_botones #(
  parameter int N_BOT    = 4,
  parameter int LONG_CNT = 50000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BOT-1:0]         boton_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BOT)-1:0] evt_id,
  output logic                     evt_long,
  output logic                     evt_drop
);
  localparam int IDW = $clog2(N_BOT);

  generate
    if (N_BOT < 2 || LONG_CNT < 2) begin : g_param_chk
      $error("arbitro_botones: N_BOT and LONG_CNT must both be >= 2");
    end
  endgenerate

  logic [N_BOT-1:0] pend_s, pend_l, drop_hit, gnt, req;
  logic [IDW-1:0]   ptr, win;
  logic             found, load;
  int               idx;

  assign req  = pend_s | pend_l;
  assign load = ~evt_valid | evt_ready;

  // Round-robin search starting one past the last granted button
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N_BOT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_BOT) idx = idx - N_BOT;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (load && found) gnt[win] = 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < N_BOT; i++) begin : g_canal
      arbitro_canal
`ifdef LONG_PRESS_EN
        #(.LONG_CNT(LONG_CNT))
`endif
        u_canal (
          .clk      (clk),
          .reset    (reset),
          .boton    (boton_in[i]),
          .clr_s    (gnt[i] & pend_s[i]),
`ifdef LONG_PRESS_EN
          .clr_l    (gnt[i] & ~pend_s[i]),
`endif
          .pend_s   (pend_s[i]),
          .pend_l   (pend_l[i]),
          .drop_hit (drop_hit[i])
        );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      ptr       <= IDW'(N_BOT - 1);
      evt_drop  <= 1'b0;
    end else begin
      evt_drop <= |drop_hit;
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_id <= win;
          ptr    <= win;
        end
      end
    end
  end

`ifdef LONG_PRESS_EN
  // Press has priority over long when both are pending for the winner
  always_ff @(posedge clk) begin
    if (reset)
      evt_long <= 1'b0;
    else if (load && found)
      evt_long <= ~pend_s[win];
  end
`else
  assign evt_long = 1'b0;
`endif
endmodule

// File: tb/tb_arbitro_botones.sv
// Scoreboard bench for arbitro_botones: reference model queues expected events, monitor checks handshakes.
module tb_arbitro_botones;
  localparam int N  = 4;
  localparam int LC = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] boton = 4'b0010;
  logic         evt_ready = 1'b0;
  logic         evt_valid, evt_long, evt_drop;
  logic [1:0]   evt_id;

  always #5 clk = ~clk;

  arbitro_botones #(.N_BOT(N), .LONG_CNT(LC)) dut (
    .clk       (clk),
    .reset     (reset),
    .boton_in  (boton),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_long  (evt_long),
    .evt_drop  (evt_drop)
  );

  typedef struct packed {
    logic [1:0] id;
    logic       lng;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;

  // Reference model: pending flags per button, round-robin pointer, hold lengths
  bit  ms[N], ml[N], mprev[N];
  int  hold[N];
  int  mptr;
  bit  mvalid, mdrop, started;

  always @(posedge clk) begin : model
    bit  ld;
    int  w, j;
    ev_t e;
    started = 1'b1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        ms[i] = 0; ml[i] = 0; hold[i] = 0; mprev[i] = boton[i];
      end
      mptr = N - 1; mvalid = 0; mdrop = 0;
      q.delete();
    end else begin
      ld = !mvalid || evt_ready;
      if (ld) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          j = (mptr + k) % N;
          if (w < 0 && (ms[j] || ml[j])) w = j;
        end
        if (w >= 0) begin
          e.id  = w[1:0];
          e.lng = !ms[w];
          q.push_back(e);
          if (ms[w]) ms[w] = 0; else ml[w] = 0;
          mptr   = w;
          mvalid = 1;
        end else begin
          mvalid = 0;
        end
      end
      mdrop = 0;
      for (int i = 0; i < N; i++) begin
        if (boton[i] && !mprev[i]) begin
          if (ms[i]) mdrop = 1;
          ms[i] = 1;
        end
`ifdef LONG_PRESS_EN
        if (boton[i]) begin
          hold[i]++;
          if (hold[i] == LC - 1) ml[i] = 1;
        end else begin
          hold[i] = 0;
        end
`endif
        mprev[i] = boton[i];
      end
    end
  end

  always @(negedge clk) begin : monitor
    ev_t h;
    if (started) begin
      tests++;
      if (evt_valid !== mvalid) begin
        fails++;
        $display("FAIL valid t=%0t got=%b exp=%b", $time, evt_valid, mvalid);
      end
      if (evt_drop || mdrop) begin
        tests++;
        if (evt_drop !== mdrop) begin
          fails++;
          $display("FAIL drop t=%0t got=%b exp=%b", $time, evt_drop, mdrop);
        end
      end
      if (!reset && evt_valid === 1'b1 && evt_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL event t=%0t got id=%0d long=%b exp=none", $time, evt_id, evt_long);
        end else begin
          h = q.pop_front();
          if (evt_id !== h.id || evt_long !== h.lng) begin
            fails++;
            $display("FAIL event t=%0t got id=%0d long=%b exp id=%0d long=%b",
                     $time, evt_id, evt_long, h.id, h.lng);
          end
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] b, input logic r, input logic rs);
    @(posedge clk);
    #2;
    boton = b; evt_ready = r; reset = rs;
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) cyc(4'b0000, r, 1'b0);
  endtask

  initial begin
    logic [N-1:0] rb;
    logic [N-1:0] fl;
    // Button held through reset: no event afterwards
    for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) cyc(4'b0010, 1'b1, 1'b0);
    idle(5, 1'b1);
    // Single one-cycle press
    cyc(4'b0100, 1'b1, 1'b0);
    idle(6, 1'b1);
    // Simultaneous presses, then wrap-around priority
    cyc(4'b1011, 1'b1, 1'b0);
    idle(6, 1'b1);
    cyc(4'b1001, 1'b1, 1'b0);
    idle(6, 1'b1);
    // Backpressure with overflow on button 1
    cyc(4'b0010, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(6, 1'b1);
    // Long hold of button 3
    for (int k = 0; k < 20; k++) cyc(4'b1000, 1'b1, 1'b0);
    idle(6, 1'b1);
    // Reset while an event is presented and others pending
    cyc(4'b0111, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    idle(10, 1'b1);
    // Randomized phase: slowly toggling buttons, random ready
    rb = '0;
    for (int k = 0; k < 800; k++) begin
      fl = '0;
      for (int b = 0; b < N; b++) fl[b] = ($urandom_range(0, 5) == 0);
      rb = rb ^ fl;
      cyc(rb, ($urandom_range(0, 3) != 0), 1'b0);
    end
    idle(30, 1'b1);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d undelivered exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
